// File: rtl/sigmoid_stream.sv
// sigmoid_stream: three-stage fixed-point sigmoid (PLAN approximation) with a
// global-stall valid/ready handshake and a sideband tag carried alongside.
// Optional build macro: SIGMOID_STREAM_STATS_EN adds stat_samples/stat_saturated.
module sigmoid_stream #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] data_out,
  output logic [TAG_W-1:0]  tag_out
`ifdef SIGMOID_STREAM_STATS_EN
  ,
  output logic [31:0]       stat_samples,
  output logic [31:0]       stat_saturated
`endif
);

  // Constants scaled by 2^FRAC_W
  localparam logic [DATA_W-1:0] ONE    = DATA_W'(1)  << FRAC_W;        // 1.0
  localparam logic [DATA_W-1:0] TH_SAT = DATA_W'(5)  << FRAC_W;        // 5.0
  localparam logic [DATA_W-1:0] TH_HI  = DATA_W'(19) << (FRAC_W - 3);  // 2.375
  localparam logic [DATA_W-1:0] C_HI   = DATA_W'(27) << (FRAC_W - 5);  // 0.84375
  localparam logic [DATA_W-1:0] C_MID  = DATA_W'(5)  << (FRAC_W - 3);  // 0.625
  localparam logic [DATA_W-1:0] C_LO   = DATA_W'(1)  << (FRAC_W - 1);  // 0.5

  if (FRAC_W < 5 || DATA_W - FRAC_W < 4 || TAG_W < 1) begin : g_param_check
    $error("sigmoid_stream: illegal DATA_W/FRAC_W/TAG_W combination");
  end

  // vld_pipe[0]=stage 1, [1]=stage 2, [2]=output register
  logic [2:0]        vld_pipe;
  logic              adv;

  logic [DATA_W-1:0] mag;
  logic [1:0]        rgn;
  logic [DATA_W-1:0] s1_m;
  logic              s1_neg;
  logic [1:0]        s1_rgn;
  logic [TAG_W-1:0]  s1_tag;

  logic [DATA_W-1:0] y_pos;
  logic [DATA_W-1:0] s2_y;
  logic              s2_neg;
  logic [TAG_W-1:0]  s2_tag;

  logic [DATA_W-1:0] res;

  // Whole pipe moves together; the output register is the only stall source
  assign adv       = !vld_pipe[2] || ready_out;
  assign ready_in  = adv;
  assign valid_out = vld_pipe[2];

  // Magnitude (most negative input maps to 2^(DATA_W-FRAC_W-1)) and region select
  always_comb begin
    mag = data_in[DATA_W-1] ? (~data_in + DATA_W'(1)) : data_in;
    rgn = 2'd0;
    if (mag >= TH_SAT)     rgn = 2'd3;
    else if (mag >= TH_HI) rgn = 2'd2;
    else if (mag >= ONE)   rgn = 2'd1;
  end

  // Piecewise-linear segment for the positive half (shifts truncate)
  always_comb begin
    y_pos = ONE;
    case (s1_rgn)
      2'd3:    y_pos = ONE;
      2'd2:    y_pos = (s1_m >> 5) + C_HI;
      2'd1:    y_pos = (s1_m >> 3) + C_MID;
      default: y_pos = (s1_m >> 2) + C_LO;
    endcase
  end

  // Symmetry for negative inputs, clamped to [0, 1.0]
  always_comb begin
    res = s2_y;
    if (s2_neg) res = (s2_y > ONE) ? '0 : ONE - s2_y;
    else        res = (s2_y > ONE) ? ONE : s2_y;
  end

  // Pipeline registers: all stages load together on adv, bubbles included
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_m     <= '0;
      s1_neg   <= 1'b0;
      s1_rgn   <= 2'd0;
      s1_tag   <= '0;
      s2_y     <= '0;
      s2_neg   <= 1'b0;
      s2_tag   <= '0;
      data_out <= '0;
      tag_out  <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[1:0], valid_in};
      s1_m     <= mag;
      s1_neg   <= data_in[DATA_W-1];
      s1_rgn   <= rgn;
      s1_tag   <= tag_in;
      s2_y     <= y_pos;
      s2_neg   <= s1_neg;
      s2_tag   <= s1_tag;
      data_out <= res;
      tag_out  <= s2_tag;
    end
  end

`ifdef SIGMOID_STREAM_STATS_EN
  // Count accepted samples and those landing in the saturated region
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_samples   <= '0;
      stat_saturated <= '0;
    end else if (valid_in && adv) begin
      stat_samples <= stat_samples + 32'd1;
      if (rgn == 2'd3) stat_saturated <= stat_saturated + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sigmoid_stream.sv
// tb_sigmoid_stream: directed + randomized checks of sigmoid_stream against an
// arithmetic reference model and an in-order scoreboard.
module tb_sigmoid_stream;
  localparam int DW = 16;
  localparam int FW = 12;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic          ready_in;
  logic [DW-1:0] data_in = '0;
  logic [TW-1:0] tag_in = '0;
  logic          valid_out;
  logic          ready_out = 1'b1;
  logic [DW-1:0] data_out;
  logic [TW-1:0] tag_out;
`ifdef SIGMOID_STREAM_STATS_EN
  logic [31:0]   stat_samples;
  logic [31:0]   stat_saturated;
`endif

  sigmoid_stream #(.DATA_W(DW), .FRAC_W(FW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in), .tag_in(tag_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .tag_out(tag_out)
`ifdef SIGMOID_STREAM_STATS_EN
    , .stat_samples(stat_samples), .stat_saturated(stat_saturated)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    int            c;
  } exp_t;

  exp_t          q[$];
  int            cmp = 0;
  int            errs = 0;
  int            cyc = 0;
  int            n_acc = 0;
  int            n_sat = 0;
  bit            lat_chk = 0;
  bit            last_acc = 0;
  bit            hold_v = 0;
  logic [DW-1:0] hold_d;
  logic [TW-1:0] hold_t;

  // Sigmoid PLAN evaluated on the real-valued input scaled by 2^FW
  function automatic logic [DW-1:0] model(input logic [DW-1:0] x);
    int one, xi, m, y;
    one = 1 << FW;
    xi  = int'(signed'(x));
    m   = (xi < 0) ? -xi : xi;
    if (m >= 5 * one)           y = one;
    else if (8 * m >= 19 * one) y = m / 32 + (27 * one) / 32;
    else if (m >= one)          y = m / 8 + (5 * one) / 8;
    else                        y = m / 4 + one / 2;
    if (xi < 0) y = one - y;
    if (y < 0) y = 0;
    if (y > one) y = one;
    return DW'(y);
  endfunction

  function automatic bit is_sat(input logic [DW-1:0] x);
    int xi;
    xi = int'(signed'(x));
    return ((xi < 0) ? -xi : xi) >= 5 * (1 << FW);
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the scoreboard, book the accept
  task automatic step(input bit r, input bit vin, input logic [DW-1:0] d,
                      input logic [TW-1:0] t, input bit ro);
    exp_t e;
    @(negedge clk);
    rst = r; valid_in = vin; data_in = d; tag_in = t; ready_out = ro;
    #1;
    last_acc = 0;
    if (hold_v) begin
      chk("stall_valid", {31'd0, valid_out}, 32'd1);
      chk("stall_data", {16'd0, data_out}, {16'd0, hold_d});
      chk("stall_tag", {28'd0, tag_out}, {28'd0, hold_t});
    end
    hold_v = 0;
    chk("ready_in", {31'd0, ready_in}, {31'd0, (!valid_out || ro)});
    if (r) begin
      q.delete();
      n_acc = 0;
      n_sat = 0;
    end else begin
      if (valid_out) begin
        if (q.size() == 0) begin
          chk("spurious_out", {31'd0, valid_out}, 32'd0);
        end else if (ro) begin
          e = q.pop_front();
          chk("data", {16'd0, data_out}, {16'd0, e.d});
          chk("tag", {28'd0, tag_out}, {28'd0, e.t});
          if (lat_chk) chk("latency", cyc - e.c, 32'd3);
        end else begin
          hold_v = 1; hold_d = data_out; hold_t = tag_out;
        end
      end
      if (vin && ready_in) begin
        e.d = model(d); e.t = t; e.c = cyc;
        q.push_back(e);
        last_acc = 1;
        n_acc++;
        if (is_sat(d)) n_sat++;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  // Cycle following a reset: outputs must be at reset values
  task automatic chk_idle();
    @(negedge clk);
    rst = 0; valid_in = 0;
    #1;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_data", {16'd0, data_out}, 32'd0);
    chk("rst_tag", {28'd0, tag_out}, 32'd0);
    chk("rst_ready", {31'd0, ready_in}, 32'd1);
`ifdef SIGMOID_STREAM_STATS_EN
    chk("rst_stat_samples", stat_samples, 32'd0);
    chk("rst_stat_saturated", stat_saturated, 32'd0);
`endif
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] dir_v [10];
    int sent, guard;
    dir_v = '{16'h0000, 16'h0800, 16'h1000, 16'h2000, 16'h3000, 16'h5000,
              16'hF000, 16'h8000, 16'hFFFF, 16'h0001};

    // Reset state
    step(1, 0, '0, '0, 1);
    step(1, 0, '0, '0, 1);
    chk_idle();

    // Back-to-back directed values, full rate, fixed 3-cycle latency
    lat_chk = 1;
    for (int i = 0; i < 10; i++) step(0, 1, dir_v[i], TW'(i), 1);
    for (int i = 0; i < 5; i++) step(0, 0, '0, '0, 1);
    lat_chk = 0;
    chk("directed_drained", q.size(), 32'd0);
    chk("known_0x3000", {16'd0, model(16'h3000)}, 32'h0F00);
    chk("known_0xF000", {16'd0, model(16'hF000)}, 32'h0400);

    // Statistics: clean reset, then 0x5000 / 0xB000 / 0x1000
    step(1, 0, '0, '0, 1);
    chk_idle();
    step(0, 1, 16'h5000, 4'd1, 1);
    step(0, 1, 16'hB000, 4'd2, 1);
    step(0, 1, 16'h1000, 4'd3, 1);
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 1);
`ifdef SIGMOID_STREAM_STATS_EN
    chk("stat_samples", stat_samples, 32'd3);
    chk("stat_saturated", stat_saturated, 32'd2);
`endif

    // 16 tagged samples under random backpressure
    sent = 0; guard = 0;
    while (sent < 16 && guard < 500) begin
      step(0, 1, DW'($urandom), TW'(sent), 1'($urandom));
      if (last_acc) sent++;
      guard++;
    end
    chk("tagged_sent", sent, 32'd16);
    guard = 0;
    while (q.size() > 0 && guard < 500) begin
      step(0, 0, '0, '0, 1'($urandom));
      guard++;
    end
    chk("tagged_drained", q.size(), 32'd0);

    // Fill the pipe with ready_out low, then drain one per cycle
    for (int i = 0; i < 8; i++) step(0, 1, DW'($urandom), TW'(i), 0);
    chk("full_inflight", q.size(), 32'd3);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, '0, '0, 1);
      chk("drain_rate", q.size(), 32'(2 - k));
    end

    // Reset with three samples in flight; nothing stale may emerge
    for (int i = 0; i < 3; i++) step(0, 1, DW'($urandom), TW'(i + 5), 1);
    step(1, 1, 16'h1234, 4'hA, 1);
    chk_idle();
    for (int i = 0; i < 6; i++) step(0, 0, '0, '0, 1);

    // Random traffic on both sides
    for (int i = 0; i < 300; i++)
      step(0, 1'($urandom), DW'($urandom), TW'($urandom), 1'($urandom_range(0, 3) != 0));
    guard = 0;
    while (q.size() > 0 && guard < 500) begin
      step(0, 0, '0, '0, 1'($urandom));
      guard++;
    end
    chk("random_drained", q.size(), 32'd0);
`ifdef SIGMOID_STREAM_STATS_EN
    chk("random_stat_samples", stat_samples, n_acc);
    chk("random_stat_saturated", stat_saturated, n_sat);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
